axi_log_arbiter: RTL

- Front-end scheduler for the AXI BRAM logger. It snoops both AXI address channels (AR and AW) on a port.
- It buffers each completed address handshake in a per-channel FIFO, then round-robin arbitrates the two FIFOs onto the logger's single log-entry input.
- It honours the logger's full status, counts events lost to FIFO overflow, and flushes all state on clear.
- The AXI master and slave drive the inputs; the BRAM logger's valid, ID, address and length inputs consume the outputs.

---
 rtl/axi_log_pkg.sv | 24 ++
 rtl/axi_log_fifo.sv | 54 +++++
 rtl/axi_log_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi_log_pkg.sv
// Shared types and helpers for the AXI address-channel logger front end.
// Entry layout is sized for the default 8-bit ID, 32-bit address, 8-bit length.
package axi_log_pkg;

    localparam int unsigned LOG_ID_BITW   = 8;
    localparam int unsigned LOG_ADDR_BITW = 32;
    localparam int unsigned LOG_LEN_BITW  = 8;

    typedef enum logic {
        LOG_CH_AR = 1'b0,
        LOG_CH_AW = 1'b1
    } log_ch_e;

    typedef struct packed {
        logic [LOG_ID_BITW-1:0]   id;
        logic [LOG_ADDR_BITW-1:0] addr;
        logic [LOG_LEN_BITW-1:0]  len;
    } log_entry_t;

    function automatic bit fifo_depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/axi_log_fifo.sv
// Purpose: synchronous FIFO with flush; push and pop may coincide even when full.
// Latency: a pushed word is visible at o_pop_dat the cycle after the push edge.
// Backpressure: pushes into a full FIFO without a same-cycle pop are discarded.
module axi_log_fifo
    import axi_log_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(log_entry_t),
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr && !i_rst) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/axi_log_arbiter.sv
// Purpose: snoop AR/AW handshakes, buffer per channel, round-robin onto one log port (filter: AXI_LOG_ARB_FILTER_EN).
// Latency: handshake in cycle N gives LogValid_SO in N+2; one entry per cycle sustained.
// Backpressure: LogReady_SI stalls the output register; LogFull_SI freezes everything; FIFO overflow counts drops.
module axi_log_arbiter
    import axi_log_pkg::*;
#(
    parameter int unsigned AXI_ADDR_BITW = 32,
    parameter int unsigned AXI_ID_BITW   = 8,
    parameter int unsigned AXI_LEN_BITW  = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned DROP_CNT_BITW = 16
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RI,
    input  logic                     ArValid_SI,
    input  logic                     ArReady_SI,
    input  logic [AXI_ID_BITW-1:0]   ArId_DI,
    input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
    input  logic                     AwValid_SI,
    input  logic                     AwReady_SI,
    input  logic [AXI_ID_BITW-1:0]   AwId_DI,
    input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
    input  logic                     LogReady_SI,
    input  logic                     LogFull_SI,
    input  logic                     Clear_SI,
`ifdef AXI_LOG_ARB_FILTER_EN
    input  logic [AXI_ADDR_BITW-1:0] FiltBase_DI,
    input  logic [AXI_ADDR_BITW-1:0] FiltMask_DI,
    input  logic                     FiltInv_SI,
`endif
    output logic                     LogValid_SO,
    output logic                     LogCh_SO,
    output logic [AXI_ID_BITW-1:0]   LogId_DO,
    output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
    output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
    output logic [DROP_CNT_BITW-1:0] DropCnt_DO
);

    localparam int unsigned ENTRY_W = AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;
    localparam int unsigned DSUM_W  = DROP_CNT_BITW + 1;

    if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_depth_chk
        $error("axi_log_arbiter: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic               w_ar_match, w_aw_match;
    logic               w_ar_cap, w_aw_cap;
    logic               w_ar_full, w_aw_full;
    logic               w_ar_empty, w_aw_empty;
    logic               w_ar_pop, w_aw_pop;
    logic               w_ar_drop, w_aw_drop;
    logic               w_load;
    log_ch_e            w_grant;
    logic [ENTRY_W-1:0] w_ar_head, w_aw_head, w_head;
    logic [DSUM_W-1:0]  w_drop_sum;

    log_ch_e                  r_rr;
    logic                     r_vld;
    log_ch_e                  r_ch;
    logic [AXI_ID_BITW-1:0]   r_id;
    logic [AXI_ADDR_BITW-1:0] r_addr;
    logic [AXI_LEN_BITW-1:0]  r_len;
    logic [DROP_CNT_BITW-1:0] r_drop_cnt;

`ifdef AXI_LOG_ARB_FILTER_EN
    assign w_ar_match = ((ArAddr_DI & FiltMask_DI) == (FiltBase_DI & FiltMask_DI)) ^ FiltInv_SI;
    assign w_aw_match = ((AwAddr_DI & FiltMask_DI) == (FiltBase_DI & FiltMask_DI)) ^ FiltInv_SI;
`else
    assign w_ar_match = 1'b1;
    assign w_aw_match = 1'b1;
`endif

    assign w_ar_cap = ArValid_SI && ArReady_SI && !LogFull_SI && !Clear_SI && w_ar_match;
    assign w_aw_cap = AwValid_SI && AwReady_SI && !LogFull_SI && !Clear_SI && w_aw_match;

    // A full logger freezes the output register as well as capture.
    assign w_load  = (!r_vld || LogReady_SI) && !LogFull_SI && !Clear_SI;
    assign w_grant = (!w_aw_empty && (w_ar_empty || r_rr == LOG_CH_AW)) ? LOG_CH_AW : LOG_CH_AR;

    assign w_ar_pop = w_load && !w_ar_empty && (w_grant == LOG_CH_AR);
    assign w_aw_pop = w_load && !w_aw_empty && (w_grant == LOG_CH_AW);

    assign w_ar_drop = w_ar_cap && w_ar_full && !w_ar_pop;
    assign w_aw_drop = w_aw_cap && w_aw_full && !w_aw_pop;

    assign w_head     = (w_grant == LOG_CH_AW) ? w_aw_head : w_ar_head;
    assign w_drop_sum = {1'b0, r_drop_cnt} + DSUM_W'(w_ar_drop) + DSUM_W'(w_aw_drop);

    axi_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ar_fifo (
        .i_clk      (Clk_CI),
        .i_rst      (Rst_RI),
        .i_clr      (Clear_SI),
        .i_push     (w_ar_cap),
        .i_push_dat ({ArId_DI, ArAddr_DI, ArLen_DI}),
        .i_pop      (w_ar_pop),
        .o_pop_dat  (w_ar_head),
        .o_full     (w_ar_full),
        .o_empty    (w_ar_empty)
    );

    axi_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_aw_fifo (
        .i_clk      (Clk_CI),
        .i_rst      (Rst_RI),
        .i_clr      (Clear_SI),
        .i_push     (w_aw_cap),
        .i_push_dat ({AwId_DI, AwAddr_DI, AwLen_DI}),
        .i_pop      (w_aw_pop),
        .o_pop_dat  (w_aw_head),
        .o_full     (w_aw_full),
        .o_empty    (w_aw_empty)
    );

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_vld      <= 1'b0;
            r_rr       <= LOG_CH_AR;
            r_drop_cnt <= '0;
        end else if (Clear_SI) begin
            r_vld      <= 1'b0;
            r_rr       <= LOG_CH_AR;
            r_drop_cnt <= '0;
        end else begin
            if (w_load) begin
                r_vld <= !w_ar_empty || !w_aw_empty;
                if (!w_ar_empty || !w_aw_empty) begin
                    r_rr <= (w_grant == LOG_CH_AW) ? LOG_CH_AR : LOG_CH_AW;
                end
            end
            // Sum carries at most 2 past the max, so the top bit flags saturation.
            r_drop_cnt <= w_drop_sum[DROP_CNT_BITW] ? '1 : w_drop_sum[DROP_CNT_BITW-1:0];
        end
    end

    // Clear leaves stale data behind a deasserted valid; only reset zeroes it.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_ch   <= LOG_CH_AR;
            r_id   <= '0;
            r_addr <= '0;
            r_len  <= '0;
        end else if (w_load && (!w_ar_empty || !w_aw_empty)) begin
            r_ch                 <= w_grant;
            {r_id, r_addr, r_len} <= w_head;
        end
    end

    assign LogValid_SO = r_vld;
    assign LogCh_SO    = r_ch;
    assign LogId_DO    = r_id;
    assign LogAddr_DO  = r_addr;
    assign LogLen_DO   = r_len;
    assign DropCnt_DO  = r_drop_cnt;

endmodule
